// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one step per clock).
// Define BCD_TO_BIN_ERRCHK_EN to flag non-decimal digits and finish those requests early.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    // After the right shift, any digit >= 8 drops by 3 (per-digit, no borrow between digits).
    function automatic logic [W-1:0] sub3_digits(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i+3])
                r[4*i +: 4] = d[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

`ifdef BCD_TO_BIN_ERRCHK_EN
    function automatic logic has_bad_digit(input logic [W-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i+3] && (d[4*i+2] || d[4*i+1]))
                bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     dig_reg;
    // Holds bits [W-1:1] of the binary accumulator; bit 0 is never needed because the
    // final result is taken combinationally as {dig_reg[0], bin_reg} on the last step.
    logic [W-2:0]     bin_reg;
    logic             accept;

    assign accept = start && (state != S_SHIFT);
    assign busy   = (state == S_SHIFT);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (accept) begin
            dig_reg <= bcd_in;
            bin_reg <= '0;
        end else if (state == S_SHIFT) begin
            dig_reg <= sub3_digits({1'b0, dig_reg[W-1:1]});
            bin_reg <= {dig_reg[0], bin_reg[W-2:1]};
        end
    end

`ifdef BCD_TO_BIN_ERRCHK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bin_out <= '0;
`ifdef BCD_TO_BIN_ERRCHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt <= '0;
`ifdef BCD_TO_BIN_ERRCHK_EN
                        if (has_bad_digit(bcd_in)) begin
                            state   <= S_DONE;
                            bin_out <= '0;
                            err_q   <= 1'b1;
                        end else begin
                            state   <= S_SHIFT;
                        end
`else
                        state <= S_SHIFT;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state   <= S_DONE;
                        bin_out <= BIN_W'({dig_reg[0], bin_reg});
`ifdef BCD_TO_BIN_ERRCHK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7); adapts to BCD_TO_BIN_ERRCHK_EN.
module tb_bcd_to_bin_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bcd_in = 8'h00;
    logic       busy;
    logic       done;
    logic [6:0] bin_out;
    logic       err;

    int checks = 0;
    int errors = 0;

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; pulses start for one cycle and waits (bounded) for done.
    task automatic run(input logic [7:0] b, input logic [6:0] exp_bin, input logic chk_bin,
                       input logic exp_err, input int exp_lat, input string tag);
        int cyc;
        int bsy;
        bcd_in = b;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        bsy = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bsy++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_busycycles"}, 32'(bsy), 32'(exp_lat));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (chk_bin) chk({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int cyc;
        int seen;

        // Asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        run(8'h99, 7'd99, 1'b1, 1'b0, 8, "max99");
        @(negedge clk);
        chk("max99_done_falls", 32'(done), 32'd0);
        chk("max99_bin_held", 32'(bin_out), 32'd99);

        // Back-to-back: second start issued in the DONE cycle of the first
        run(8'h00, 7'd0, 1'b1, 1'b0, 8, "zero");
        run(8'h45, 7'd45, 1'b1, 1'b0, 8, "b2b45");
        @(negedge clk);
        chk("b2b45_done_falls", 32'(done), 32'd0);

`ifdef BCD_TO_BIN_ERRCHK_EN
        run(8'h1A, 7'd0, 1'b1, 1'b1, 0, "bad1A");
`else
        run(8'h1A, 7'd0, 1'b0, 1'b0, 8, "nochk1A");
`endif
        run(8'h37, 7'd37, 1'b1, 1'b0, 8, "v37");
        run(8'h10, 7'd10, 1'b1, 1'b0, 8, "v10");
        run(8'h09, 7'd9, 1'b1, 1'b0, 8, "v09");
        run(8'h90, 7'd90, 1'b1, 1'b0, 8, "v90");
        run(8'h88, 7'd88, 1'b1, 1'b0, 8, "v88");
        @(negedge clk);

        // Start while busy is ignored; bcd_in changes mid-conversion have no effect
        bcd_in = 8'h21;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        @(negedge clk);
        cyc++;
        @(negedge clk);
        cyc++;
        bcd_in = 8'h34;
        start  = 1'b1;
        @(negedge clk);
        cyc++;
        start  = 1'b0;
        bcd_in = 8'h77;
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_bin_held", 32'(bin_out), 32'd88);
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_latency", 32'(cyc), 32'd8);
        chk("ign_bin", 32'(bin_out), 32'd21);
        @(negedge clk);
        @(negedge clk);
        chk("ign_no_restart_busy", 32'(busy), 32'd0);
        chk("ign_no_restart_done", 32'(done), 32'd0);
        chk("ign_bin_stable", 32'(bin_out), 32'd21);

        // Reset in the middle of a conversion
        bcd_in = 8'h58;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bin", 32'(bin_out), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_no_activity", 32'(seen), 32'd0);
        chk("abort_bin_stays", 32'(bin_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
